pe_simd_ctrl: RTL and testbench

Job sequencer for a single `pe_simd` processing element. It accepts one job descriptor: instruction count, data count and expected result count. It streams that many instructions from an upstream instruction port into the PE, inserts a fixed idle gap, then streams that many data words. It collects the PE results, forwards each one downstream, and signals completion. It sits between the array-level loader/FIFOs and each `pe_simd` instance.

---
 rtl/pe_simd_ctrl.sv | 128 ++++++++++++
 tb/tb_pe_simd_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_simd_ctrl.sv
// pe_simd_ctrl: job sequencer for one pe_simd; streams instructions, an idle gap, data, then drains results.
// Define PE_CTRL_TIMEOUT_EN to enable the drain watchdog that raises err.
module pe_simd_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int CNT_W      = 8,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_inst,
    input  logic [CNT_W-1:0]        num_data,
    input  logic [CNT_W-1:0]        num_out,
    input  logic                    inst_s_v,
    output logic                    inst_s_rdy,
    input  logic [INST_WIDTH-1:0]   inst_s,
    input  logic                    data_s_v,
    output logic                    data_s_rdy,
    input  logic [2*DATA_WIDTH-1:0] data_s,
    output logic                    inst_in_v,
    output logic [INST_WIDTH-1:0]   inst_in,
    output logic                    din_v,
    output logic [2*DATA_WIDTH-1:0] din_pe,
    input  logic                    dout_v,
    input  logic [2*DATA_WIDTH-1:0] dout_pe,
    output logic                    res_v,
    output logic [2*DATA_WIDTH-1:0] res,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD_INST = 3'd1;
    localparam logic [2:0] GAP       = 3'd2;
    localparam logic [2:0] LOAD_DATA = 3'd3;
    localparam logic [2:0] DRAIN     = 3'd4;
    // one timer serves the gap count and the drain watchdog, so it is sized for the larger of the two
    localparam int TMR_W = $clog2((GAP_CYCLES > TIMEOUT ? GAP_CYCLES : TIMEOUT) + 2);

    logic [2:0]       state;
    logic [CNT_W-1:0] lat_inst, lat_data, lat_out;
    logic [CNT_W-1:0] inst_cnt, data_cnt, out_cnt;
    logic [CNT_W-1:0] inst_nxt, data_nxt, out_nxt;
    logic [TMR_W-1:0] tmr;
    logic             inst_hs, data_hs, accept, gap_last, out_hit, wd_run, wd_fire;

    always_comb begin
        busy       = state != IDLE;
        inst_s_rdy = (state == LOAD_INST) && (inst_cnt < lat_inst);
        data_s_rdy = (state == LOAD_DATA) && (data_cnt < lat_data);
        inst_hs    = inst_s_v && inst_s_rdy;
        data_hs    = data_s_v && data_s_rdy;
        inst_nxt   = inst_cnt + CNT_W'(inst_hs);
        data_nxt   = data_cnt + CNT_W'(data_hs);
        out_nxt    = out_cnt + CNT_W'(dout_v && busy && (out_cnt < lat_out));
        accept     = start && !busy && !done;
        gap_last   = tmr == TMR_W'(GAP_CYCLES - 1);
        out_hit    = out_nxt == lat_out;
    end

`ifdef PE_CTRL_TIMEOUT_EN
    assign wd_run  = (state == DRAIN) && !dout_v;
    assign wd_fire = wd_run && (tmr == TMR_W'(TIMEOUT - 1));
`else
    assign wd_run  = 1'b0;
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            lat_inst <= '0;
            lat_data <= '0;
            lat_out  <= '0;
            inst_cnt <= '0;
            data_cnt <= '0;
            out_cnt  <= '0;
            tmr      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else if (accept) begin
            state    <= LOAD_INST;
            lat_inst <= num_inst;
            lat_data <= num_data;
            lat_out  <= num_out;
            inst_cnt <= '0;
            data_cnt <= '0;
            out_cnt  <= '0;
            tmr      <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            inst_cnt <= inst_nxt;
            data_cnt <= data_nxt;
            out_cnt  <= out_nxt;
            tmr      <= (((state == GAP) && !gap_last) || wd_run) ? tmr + 1'b1 : '0;
            done     <= (state == DRAIN) && (out_hit || wd_fire);
            err      <= err || ((state == DRAIN) && !out_hit && wd_fire);
            case (state)
                LOAD_INST: if (inst_nxt == lat_inst) state <= (GAP_CYCLES == 0) ? LOAD_DATA : GAP;
                GAP:       if (gap_last) state <= LOAD_DATA;
                LOAD_DATA: if (data_nxt == lat_data) state <= DRAIN;
                DRAIN:     if (out_hit || wd_fire) state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_in_v <= 1'b0;
            inst_in   <= '0;
            din_v     <= 1'b0;
            din_pe    <= '0;
            res_v     <= 1'b0;
            res       <= '0;
        end else begin
            inst_in_v <= inst_hs;
            inst_in   <= inst_hs ? inst_s : '0;
            din_v     <= data_hs;
            din_pe    <= data_hs ? data_s : '0;
            res_v     <= dout_v;
            res       <= dout_v ? dout_pe : '0;
        end
    end
endmodule

// File: tb/tb_pe_simd_ctrl.sv
// tb_pe_simd_ctrl: randomized scoreboard bench for pe_simd_ctrl in its default build (watchdog disabled).
module tb_pe_simd_ctrl;
    localparam int DW  = 16;
    localparam int IW  = 32;
    localparam int CW  = 8;
    localparam int GAP = 2;

    logic            clk = 0, rst = 1, start = 0;
    logic [CW-1:0]   num_inst = 0, num_data = 0, num_out = 0;
    logic            inst_s_v = 0, inst_s_rdy, data_s_v = 0, data_s_rdy;
    logic [IW-1:0]   inst_s = 0, inst_in;
    logic [2*DW-1:0] data_s = 0, din_pe, dout_pe = 0, res;
    logic            inst_in_v, din_v, dout_v = 0, res_v, busy, done, err;

    pe_simd_ctrl #(.DATA_WIDTH(DW), .INST_WIDTH(IW), .CNT_W(CW), .GAP_CYCLES(GAP), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .start(start), .num_inst(num_inst), .num_data(num_data), .num_out(num_out),
        .inst_s_v(inst_s_v), .inst_s_rdy(inst_s_rdy), .inst_s(inst_s),
        .data_s_v(data_s_v), .data_s_rdy(data_s_rdy), .data_s(data_s),
        .inst_in_v(inst_in_v), .inst_in(inst_in), .din_v(din_v), .din_pe(din_pe),
        .dout_v(dout_v), .dout_pe(dout_pe), .res_v(res_v), .res(res),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic [2*DW-1:0] d; int c; } res_t;
    logic [IW-1:0]   inst_list[$], inst_q[$];
    logic [2*DW-1:0] data_list[$], din_q[$];
    res_t            res_q[$];
    int checks = 0, failures = 0, cyc = 0;
    bit job_active = 0, exact_gap = 0, abort = 0, data_fed = 0;
    int job_ni = 0, exp_out = 0, res_cnt = 0, k_cyc = 0, last_inst_cyc = 0, last_din_cyc = 0, din_n = 0;
    int din_cyc[64];

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: pops expected words as the DUT presents them, independent of the stimulus processes
    always @(negedge clk) begin : mon
        logic [63:0] e;
        res_t r;
        int ed;
        if (rst) begin
            if (inst_in_v) begin
                if (inst_q.size() == 0) chk(0, "inst_unexpected", inst_in, 0);
                else begin
                    e = inst_q.pop_front();
                    chk(inst_in == e[IW-1:0], "inst_in", inst_in, e);
                end
                last_inst_cyc = cyc;
            end else chk(inst_in == 0, "inst_in_idle_zero", inst_in, 0);
            if (din_v) begin
                if (din_q.size() == 0) chk(0, "din_unexpected", din_pe, 0);
                else begin
                    e = din_q.pop_front();
                    chk(din_pe == e[2*DW-1:0], "din_pe", din_pe, e);
                end
                if (din_n == 0 && job_ni > 0)
                    chk(exact_gap ? (cyc - last_inst_cyc - 1 == GAP) : (cyc - last_inst_cyc - 1 >= GAP),
                        "gap_cycles", cyc - last_inst_cyc - 1, GAP);
                if (din_n < 64) din_cyc[din_n] = cyc;
                din_n++;
                last_din_cyc = cyc;
            end else chk(din_pe == 0, "din_idle_zero", din_pe, 0);
            if (res_v) begin
                if (res_q.size() == 0) chk(0, "res_unexpected", res, 0);
                else begin
                    r = res_q.pop_front();
                    chk(res == r.d && cyc == r.c, "res_echo", {res, 32'(cyc)}, {r.d, 32'(r.c)});
                end
            end else if (res_q.size() != 0 && res_q[0].c <= cyc) begin
                r = res_q.pop_front();
                chk(0, "res_missing", 0, r.d);
            end
            if (dout_v) begin
                res_q.push_back('{dout_pe, cyc + 1});
                if (job_active && busy && res_cnt < exp_out) begin
                    res_cnt++;
                    if (res_cnt == exp_out) k_cyc = cyc + 1;
                end
            end
            if (job_active && job_ni == 0) chk(!inst_s_rdy, "inst_rdy_zero_job", inst_s_rdy, 0);
            if (done) begin
                if (!job_active) chk(0, "done_unexpected", 1, 0);
                else begin
                    ed = (k_cyc > last_din_cyc + 1) ? k_cyc : last_din_cyc + 1;
                    chk(cyc == ed, "done_time", cyc, ed);
                    chk(inst_q.size() + din_q.size() == 0, "streams_complete", inst_q.size() + din_q.size(), 0);
                    chk(res_cnt == exp_out, "results_counted", res_cnt, exp_out);
                    chk(!busy && !err, "busy_err_at_done", {busy, err}, 0);
                    job_active = 0;
                end
            end
        end
    end

    task automatic rand_lists(input int ni, input int nd);
        inst_list.delete();
        data_list.delete();
        repeat (ni) inst_list.push_back($urandom);
        repeat (nd) data_list.push_back($urandom);
    endtask

    task automatic feed_inst(input int n, input int stall);
        int i = 0, it = 0;
        bit hs;
        while (i < n && !abort && it < 400) begin
            inst_s_v = $urandom_range(99) >= stall;
            inst_s = inst_list[i];
            @(negedge clk);
            hs = inst_s_v && inst_s_rdy;
            @(posedge clk); #1;
            if (hs) i++;
            it++;
        end
        inst_s_v = 0;
        inst_s = 0;
    endtask

    task automatic feed_data(input int n, input int stall, input int hold);
        int i = 0, it = 0;
        bit hs, held = 0;
        while (i < n && !abort && it < 400) begin
            if (i == hold && !held) begin
                data_s_v = 0;
                data_s = 0;
                repeat (4) begin @(posedge clk); #1; end
                held = 1;
            end
            data_s_v = $urandom_range(99) >= stall;
            data_s = data_list[i];
            @(negedge clk);
            hs = data_s_v && data_s_rdy;
            @(posedge clk); #1;
            if (hs) i++;
            it++;
        end
        data_s_v = 0;
        data_s = 0;
        data_fed = 1;
    endtask

    task automatic drive_res(input int n, input bit early);
        int w = 0;
        if (!early) while (!data_fed && !abort && w < 1000) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < n && !abort; i++) begin
            repeat ($urandom_range(2)) begin @(posedge clk); #1; end
            dout_v = 1;
            dout_pe = $urandom;
            @(posedge clk); #1;
            dout_v = 0;
            dout_pe = 0;
        end
    endtask

    task automatic do_reset(input int at);
        int w = 0;
        while (din_n < at && w < 300) begin @(negedge clk); w++; end
        @(posedge clk); #3;
        rst = 0;
        abort = 1;
        #1;
        chk({inst_s_rdy, data_s_rdy, inst_in_v, din_v, res_v, busy, done, err} == 0 &&
            inst_in == 0 && din_pe == 0 && res == 0, "reset_outputs_zero",
            {inst_s_rdy, data_s_rdy, inst_in_v, din_v, res_v, busy, done, err}, 0);
        inst_q.delete();
        din_q.delete();
        res_q.delete();
        job_active = 0;
    endtask

    task automatic run_job(input int no, input int stall, input int extra, input bit early, input bit exact,
                           input bit poke, input int rst_at, input int hold);
        int ni = inst_list.size(), nd = data_list.size();
        foreach (inst_list[i]) inst_q.push_back(inst_list[i]);
        foreach (data_list[i]) din_q.push_back(data_list[i]);
        job_ni = ni;
        exp_out = no;
        res_cnt = 0;
        k_cyc = 0;
        last_din_cyc = -100;
        last_inst_cyc = -100;
        din_n = 0;
        exact_gap = exact;
        abort = 0;
        data_fed = 0;
        job_active = 1;
        num_inst = CW'(ni);
        num_data = CW'(nd);
        num_out = CW'(no);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        fork
            feed_inst(ni, stall);
            feed_data(nd, stall, hold);
            drive_res(no + extra, early);
            if (rst_at >= 0) do_reset(rst_at);
        join
        if (abort) begin
            repeat (3) @(posedge clk);
            #1 rst = 1;
            abort = 0;
            repeat (15) @(posedge clk);
            #1;
            return;
        end
        for (int w = 0; w < 300 && job_active; w++) begin
            @(negedge clk);
            if (done && poke) begin
                num_inst = 1;
                num_data = 1;
                num_out = 0;
                start = 1;
                @(posedge clk); #1;
                start = 0;
                @(negedge clk);
                chk(!busy, "start_on_done_ignored", busy, 0);
            end
        end
        if (job_active) begin
            chk(0, "done_timeout", 0, 1);
            job_active = 0;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk({inst_s_rdy, data_s_rdy, inst_in_v, din_v, res_v, busy, done, err} == 0 &&
            inst_in == 0 && din_pe == 0 && res == 0, "reset_state",
            {inst_s_rdy, data_s_rdy, inst_in_v, din_v, res_v, busy, done, err}, 0);
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        inst_list = '{32'h60010080, 32'h60030281, 32'h60050482};
        data_list = '{32'h00040002, 32'h00030001, 32'h00080006, 32'h00070005, 32'h000c000a, 32'h000b0009};
        run_job(3, 0, 0, 0, 1, 0, -1, -1);
        chk(din_cyc[5] - din_cyc[0] == 5, "din_back_to_back", din_cyc[5] - din_cyc[0], 5);
        rand_lists(2, 6);
        run_job(2, 0, 0, 0, 1, 0, -1, 3);
        chk(din_cyc[3] - din_cyc[2] - 1 == 4, "stall_hole", din_cyc[3] - din_cyc[2] - 1, 4);
        rand_lists(0, 2);
        run_job(0, 0, 0, 0, 0, 0, -1, -1);
        rand_lists(2, 5);
        run_job(2, 0, 0, 1, 0, 0, -1, -1);
        rand_lists(1, 2);
        run_job(1, 0, 2, 0, 0, 0, -1, -1);
        rand_lists(1, 1);
        run_job(1, 0, 0, 0, 0, 1, -1, -1);
        rand_lists(2, 8);
        run_job(2, 0, 0, 0, 0, 0, 3, -1);
        rand_lists(2, 3);
        run_job(2, 0, 0, 0, 1, 0, -1, -1);
        repeat (12) begin
            rand_lists($urandom_range(5), $urandom_range(6, 1));
            run_job($urandom_range(4), 30, 0, 1'($urandom_range(1)), 0, 0, -1, -1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
